tdm_mux_8_1: RTL and testbench



---
 rtl/tdm_mux_8_1.sv | 171 +++++++++++++++++
 tb/tb_tdm_mux_8_1.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_8_1.sv
// tdm_mux_8_1: 8:1 time-division multiplexer feeding a 1:8 demux.
// Takes one 8-channel frame per handshake and emits one channel per clock on D
// together with the select code {a,b,c} = channel index.
// Optional build macro TDM_MUX_MASK_EN adds a per-frame channel enable mask.
module tdm_mux_8_1 #(
    parameter int WIDTH = 1,
    parameter int GAP   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] din,
    input  logic               in_valid,
`ifdef TDM_MUX_MASK_EN
    input  logic [7:0]         ch_mask,
`endif
    output logic               in_ready,
    output logic [WIDTH-1:0]   D,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d_valid,
    output logic               frame_start,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SEND, GAPW} state_t;

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] GAP_LD = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t               state_q, state_d;
    logic [2:0]           ch_q, ch_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [8*WIDTH-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [2:0]           sel_q, sel_d;
    logic                 dv_q, dv_d;
    logic                 fs_q, fs_d;
    logic [7:0]           ld_mask;

`ifdef TDM_MUX_MASK_EN
    logic [7:0] mask_q, mask_d;
    assign ld_mask = ch_mask;
`else
    // Every channel is always enabled; the scan logic collapses to a plain counter.
    logic [7:0] mask_q;
    assign mask_q  = 8'hFF;
    assign ld_mask = 8'hFF;
`endif

    logic [2:0] last_ch, nxt_ch, ld_first;
    logic       ld_any, accept, do_exit;

    // Channel scan: highest enabled, next enabled above ch, first enabled in new mask.
    always_comb begin
        last_ch  = 3'd0;
        nxt_ch   = ch_q;
        ld_first = 3'd0;
        for (int k = 0; k < 8; k++)
            if (mask_q[k]) last_ch = 3'(k);
        for (int k = 7; k >= 0; k--) begin
            if (mask_q[k] && k > int'(ch_q)) nxt_ch = 3'(k);
            if (ld_mask[k]) ld_first = 3'(k);
        end
        ld_any = |ld_mask;
    end

    // Ready only in IDLE, or on the last channel of a frame when frames may abut.
    always_comb begin
        in_ready = rst_n && ((state_q == IDLE) ||
                   (GAP == 0 && state_q == SEND && ch_q == last_ch));
    end

    assign accept = in_valid && in_ready;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        d_d     = d_q;
        sel_d   = sel_q;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        do_exit = 1'b0;
`ifdef TDM_MUX_MASK_EN
        mask_d  = mask_q;
`endif
        if (accept) begin
            buf_d = din;
`ifdef TDM_MUX_MASK_EN
            mask_d = ld_mask;
`endif
            if (ld_any) begin
                state_d = SEND;
                ch_d    = ld_first;
                sel_d   = ld_first;
                d_d     = din[ld_first*WIDTH +: WIDTH];
                dv_d    = 1'b1;
                fs_d    = 1'b1;
            end else begin
                do_exit = 1'b1;
            end
        end else begin
            case (state_q)
                SEND: begin
                    if (ch_q != last_ch) begin
                        ch_d  = nxt_ch;
                        sel_d = nxt_ch;
                        d_d   = buf_q[nxt_ch*WIDTH +: WIDTH];
                        dv_d  = 1'b1;
                    end else begin
                        do_exit = 1'b1;
                    end
                end
                GAPW: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
        if (do_exit) begin
            if (GAP > 0) begin
                state_d = GAPW;
                cnt_d   = GAP_LD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            d_q     <= '0;
            sel_q   <= '0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef TDM_MUX_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            d_q     <= d_d;
            sel_q   <= sel_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
`ifdef TDM_MUX_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign D           = d_q;
    assign a           = sel_q[2];
    assign b           = sel_q[1];
    assign c           = sel_q[0];
    assign d_valid     = dv_q;
    assign frame_start = fs_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Directed bench for tdm_mux_8_1: three instances (GAP=0, GAP=3, WIDTH=4).
module tb_tdm_mux_8_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic rst_n;

    // u0: WIDTH=1, GAP=0
    logic [7:0] din0;
    logic iv0, ir0, D0, a0, b0, c0, dv0, fs0, bz0;
    // u1: WIDTH=1, GAP=3
    logic [7:0] din1;
    logic iv1, ir1, D1, a1, b1, c1, dv1, fs1, bz1;
    // u2: WIDTH=4, GAP=0
    logic [31:0] din2;
    logic [3:0] D2;
    logic [7:0] mask2;
    logic iv2, ir2, a2, b2, c2, dv2, fs2, bz2;

    tdm_mux_8_1 #(.WIDTH(1), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din0), .in_valid(iv0),
`ifdef TDM_MUX_MASK_EN
        .ch_mask(8'hFF),
`endif
        .in_ready(ir0), .D(D0), .a(a0), .b(b0), .c(c0),
        .d_valid(dv0), .frame_start(fs0), .busy(bz0));

    tdm_mux_8_1 #(.WIDTH(1), .GAP(3)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .in_valid(iv1),
`ifdef TDM_MUX_MASK_EN
        .ch_mask(8'hFF),
`endif
        .in_ready(ir1), .D(D1), .a(a1), .b(b1), .c(c1),
        .d_valid(dv1), .frame_start(fs1), .busy(bz1));

    tdm_mux_8_1 #(.WIDTH(4), .GAP(0)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .in_valid(iv2),
`ifdef TDM_MUX_MASK_EN
        .ch_mask(mask2),
`endif
        .in_ready(ir2), .D(D2), .a(a2), .b(b2), .c(c2),
        .d_valid(dv2), .frame_start(fs2), .busy(bz2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv0 = 1'b1; din0 = 8'hFF; iv1 = 1'b1; din1 = 8'hFF;
        iv2 = 1'b1; din2 = '1; mask2 = 8'hFF;
        #1;
        n_chk++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre got=%b exp=0", ir0); end
        tick(); tick();
        n_chk++; if (ir0 !== 1'b0 || dv0 !== 1'b0 || fs0 !== 1'b0 || bz0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl got ir=%b dv=%b fs=%b bz=%b exp 0000", ir0, dv0, fs0, bz0); end
        n_chk++; if ({D0, a0, b0, c0} !== 4'b0) begin
            n_fail++; $display("FAIL reset_data got D=%b abc=%b%b%b exp 0/000", D0, a0, b0, c0); end
        rst_n = 1'b1; iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        #1;
        n_chk++; if (ir0 !== 1'b1 || bz0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got ir=%b bz=%b exp ir=1 bz=0", ir0, bz0); end
    endtask

    task automatic test_single();
        logic [7:0] expd;
        expd = 8'b1011_0010;  // channel k is bit k
        din0 = 8'b1011_0010; iv0 = 1'b1;
        tick();               // accept edge T
        iv0 = 1'b0; din0 = 8'h00;  // later din changes must not matter
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (dv0 !== 1'b1 || {a0, b0, c0} !== 3'(k) || D0 !== expd[k] || fs0 !== (k == 0)) begin
                n_fail++; $display("FAIL single_ch%0d got dv=%b abc=%b%b%b D=%b fs=%b exp dv=1 abc=%0d D=%b fs=%b",
                                   k, dv0, a0, b0, c0, D0, fs0, k, expd[k], (k == 0)); end
            tick();
        end
        n_chk++; if (dv0 !== 1'b0 || bz0 !== 1'b0 || ir0 !== 1'b1) begin
            n_fail++; $display("FAIL single_end got dv=%b bz=%b ir=%b exp 0 0 1", dv0, bz0, ir0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expd;
        expd = 16'hC35A;  // frame0 bits then frame1 bits
        din0 = 8'h5A; iv0 = 1'b1;
        tick();
        din0 = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (dv0 !== 1'b1 || {a0, b0, c0} !== 3'(i % 8) || D0 !== expd[i] ||
                         fs0 !== (i % 8 == 0) || ir0 !== (i % 8 == 7)) begin
                n_fail++; $display("FAIL b2b_cyc%0d got dv=%b abc=%b%b%b D=%b fs=%b ir=%b exp D=%b ch=%0d",
                                   i, dv0, a0, b0, c0, D0, fs0, ir0, expd[i], i % 8); end
            if (i == 8) iv0 = 1'b0;
            tick();
        end
        n_chk++; if (dv0 !== 1'b0 || bz0 !== 1'b0 || ir0 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_end got dv=%b bz=%b ir=%b exp 0 0 1", dv0, bz0, ir0); end
    endtask

    task automatic test_gap();
        logic [7:0] y;
        din1 = 8'h5A; iv1 = 1'b1;
        tick();
        din1 = 8'hC3;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (dv1 !== 1'b1 || ir1 !== 1'b0) begin
                n_fail++; $display("FAIL gap_f0_cyc%0d got dv=%b ir=%b exp 1 0", i, dv1, ir1); end
            if (dv1 === 1'b1) y[{a1, b1, c1}] = D1;
            tick();
        end
        n_chk++; if (y !== 8'h5A) begin n_fail++; $display("FAIL gap_loop0 got=%h exp=5a", y); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (dv1 !== 1'b0 || ir1 !== 1'b0 || bz1 !== 1'b1 || {a1, b1, c1} !== 3'd7 || D1 !== 1'b0) begin
                n_fail++; $display("FAIL gap_wait%0d got dv=%b ir=%b bz=%b abc=%b%b%b D=%b exp 0 0 1 111 0",
                                   i, dv1, ir1, bz1, a1, b1, c1, D1); end
            tick();
        end
        n_chk++; if (ir1 !== 1'b1 || bz1 !== 1'b0 || dv1 !== 1'b0) begin
            n_fail++; $display("FAIL gap_idle got ir=%b bz=%b dv=%b exp 1 0 0", ir1, bz1, dv1); end
        tick();
        iv1 = 1'b0;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (dv1 !== 1'b1 || {a1, b1, c1} !== 3'(i)) begin
                n_fail++; $display("FAIL gap_f1_cyc%0d got dv=%b abc=%b%b%b exp 1 %0d", i, dv1, a1, b1, c1, i); end
            if (dv1 === 1'b1) y[{a1, b1, c1}] = D1;
            tick();
        end
        n_chk++; if (y !== 8'hC3) begin n_fail++; $display("FAIL gap_loop1 got=%h exp=c3", y); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        din0 = 8'h96; iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        repeat (4) tick();
        n_chk++; if ({a0, b0, c0} !== 3'd4 || dv0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre got abc=%b%b%b dv=%b exp 100 1", a0, b0, c0, dv0); end
        rst_n = 1'b0;
        tick();
        n_chk++; if (dv0 !== 1'b0 || D0 !== 1'b0 || {a0, b0, c0} !== 3'd0 || bz0 !== 1'b0 || fs0 !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got dv=%b D=%b abc=%b%b%b bz=%b fs=%b exp all 0",
                               dv0, D0, a0, b0, c0, bz0, fs0); end
        rst_n = 1'b1; din0 = 8'hFF; iv0 = 1'b1;
        #1;
        n_chk++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", ir0); end
        tick();
        iv0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (dv0 !== 1'b1 || D0 !== 1'b1 || {a0, b0, c0} !== 3'(k)) begin
                n_fail++; $display("FAIL mid_ch%0d got dv=%b D=%b abc=%b%b%b exp 1 1 %0d", k, dv0, D0, a0, b0, c0, k); end
            tick();
        end
    endtask

    task automatic test_mask();
        din2 = 32'h8765_4321;  // channel k carries k+1
`ifdef TDM_MUX_MASK_EN
        mask2 = 8'b1000_0101; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        n_chk++; if (dv2 !== 1'b1 || {a2, b2, c2} !== 3'd0 || D2 !== 4'd1 || fs2 !== 1'b1 || ir2 !== 1'b0) begin
            n_fail++; $display("FAIL mask_c0 got dv=%b abc=%b%b%b D=%0d fs=%b ir=%b exp 1 000 1 1 0", dv2, a2, b2, c2, D2, fs2, ir2); end
        tick();
        n_chk++; if (dv2 !== 1'b1 || {a2, b2, c2} !== 3'd2 || D2 !== 4'd3 || fs2 !== 1'b0 || ir2 !== 1'b0) begin
            n_fail++; $display("FAIL mask_c2 got dv=%b abc=%b%b%b D=%0d fs=%b ir=%b exp 1 010 3 0 0", dv2, a2, b2, c2, D2, fs2, ir2); end
        tick();
        n_chk++; if (dv2 !== 1'b1 || {a2, b2, c2} !== 3'd7 || D2 !== 4'd8 || ir2 !== 1'b1) begin
            n_fail++; $display("FAIL mask_c7 got dv=%b abc=%b%b%b D=%0d ir=%b exp 1 111 8 1", dv2, a2, b2, c2, D2, ir2); end
        tick();
        n_chk++; if (dv2 !== 1'b0 || bz2 !== 1'b0) begin
            n_fail++; $display("FAIL mask_end got dv=%b bz=%b exp 0 0", dv2, bz2); end
        mask2 = 8'h00; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (dv2 !== 1'b0 || ir2 !== 1'b1 || bz2 !== 1'b0) begin
                n_fail++; $display("FAIL mask_zero%0d got dv=%b ir=%b bz=%b exp 0 1 0", i, dv2, ir2, bz2); end
            tick();
        end
`else
        iv2 = 1'b1;
        tick();
        iv2 = 1'b0; din2 = '0;
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (dv2 !== 1'b1 || {a2, b2, c2} !== 3'(k) || D2 !== 4'(k + 1)) begin
                n_fail++; $display("FAIL w4_ch%0d got dv=%b abc=%b%b%b D=%0d exp 1 %0d %0d", k, dv2, a2, b2, c2, D2, k, k + 1); end
            tick();
        end
        n_chk++; if (dv2 !== 1'b0 || bz2 !== 1'b0) begin
            n_fail++; $display("FAIL w4_end got dv=%b bz=%b exp 0 0", dv2, bz2); end
`endif
    endtask

    initial begin
        rst_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; mask2 = 8'hFF;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
